// File: rtl/display_pkg.sv
// Shared types and constants for the eight-digit multiplexed BCD display.
// Contents:
//   N_DIGITS      number of display digits
//   BLANK_CODE    code that the downstream seven-segment decoder shows as all segments off
//   conv_state_t  state of the sequential binary-to-BCD converter
//   bcd_digits_t  display register, one 4-bit BCD digit per position (digit 0 least significant)
//   dabble_adjust one double-dabble correction step applied to the whole accumulator
package display_pkg;

    localparam int unsigned N_DIGITS   = 8;
    localparam logic [3:0]  BLANK_CODE = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        DONE
    } conv_state_t;

    typedef logic [N_DIGITS-1:0][3:0] bcd_digits_t;

    // Add 3 to every nibble that is 5 or more, so the following left shift
    // carries correctly into the next decimal digit.
    function automatic logic [4*N_DIGITS-1:0] dabble_adjust(input logic [4*N_DIGITS-1:0] acc);
        logic [4*N_DIGITS-1:0] res;
        res = acc;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with an output display register.
// A load in IDLE starts a BIN_W-iteration conversion (one bit per cycle); the finished
// result is copied into the display register in DONE, so the outputs never show a
// partially converted value.
// Ports:
//   clk     clock
//   reset   asynchronous active-high reset (clears the display register, aborts conversion)
//   load    request to convert bin_in; ignored while busy
//   bin_in  binary value, sampled on the edge where load is accepted
//   busy    high while a conversion is in progress
//   digits  display register, 8 BCD digits, digit 0 in bits [3:0]
module bin_to_bcd_seq
    import display_pkg::*;
#(
    parameter int unsigned BIN_W = 26
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [BIN_W-1:0]        bin_in,
    output logic                    busy,
    output logic [4*N_DIGITS-1:0]   digits
);

    localparam int unsigned ACC_W = 4 * N_DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    conv_state_t      state;
    conv_state_t      state_next;
    logic [BIN_W-1:0] shift_reg;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_adj;
    logic [CNT_W-1:0] bit_cnt;
    logic             last_bit;

    assign acc_adj  = dabble_adjust(acc);
    assign last_bit = (bit_cnt == CNT_W'(BIN_W - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load) state_next = CONVERT;
            CONVERT: if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg <= '0;
            acc       <= '0;
            bit_cnt   <= '0;
            digits    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        shift_reg <= bin_in;
                        acc       <= '0;
                        bit_cnt   <= '0;
                    end
                end
                CONVERT: begin
                    {acc, shift_reg} <= {acc_adj[ACC_W-2:0], shift_reg, 1'b0};
                    bit_cnt          <= bit_cnt + 1'b1;
                end
                DONE: begin
                    digits <= acc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/display_mux_bcd.sv
// Time-multiplexed 8-digit driver for a common-anode seven-segment display.
// Converts bin_in to BCD, holds the digits and scans them one per slot of
// REFRESH_DIV cycles, presenting the selected digit code and its anode strobe.
// Ports:
//   clk       clock
//   reset     asynchronous active-high reset
//   load      single-cycle request to convert bin_in (dropped while busy)
//   bin_in    binary value to display
//   blank_lz  enable leading-zero blanking (digit 0 is never blanked)
//   busy      conversion in progress
//   bcd_out   code for the selected digit, BLANK_CODE when blanked
//   anodes    active-low digit enables, bit i selects digit i
module display_mux_bcd
    import display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BIN_W       = 26
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [BIN_W-1:0] bin_in,
    input  logic             blank_lz,
    output logic             busy,
    output logic [3:0]       bcd_out,
    output logic [7:0]       anodes
);

    localparam int unsigned PRE_W = $clog2(REFRESH_DIV);

    logic [4*N_DIGITS-1:0] digits;
    logic [4*N_DIGITS-1:0] upper;
    logic [PRE_W-1:0]      prescaler;
    logic [2:0]            idx;

    bin_to_bcd_seq #(
        .BIN_W (BIN_W)
    ) u_conv (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .bin_in (bin_in),
        .busy   (busy),
        .digits (digits)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
            idx       <= '0;
        end else if (prescaler == PRE_W'(REFRESH_DIV - 1)) begin
            prescaler <= '0;
            idx       <= idx + 1'b1;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // Shifting the display register down by the selected position leaves the
    // selected digit and every higher digit; all-zero means it is a leading zero.
    always_comb begin
        upper   = digits >> {idx, 2'b00};
        anodes  = ~(8'd1 << idx);
        bcd_out = upper[3:0];
        if (blank_lz && (idx != 3'd0) && (upper == '0)) begin
            bcd_out = BLANK_CODE;
        end
    end

endmodule

// File: tb/tb_display_mux_bcd.sv
// Self-checking bench for display_mux_bcd: directed cases plus random values,
// compared against a decimal-arithmetic reference model.
module tb_display_mux_bcd;

    localparam int unsigned RD    = 4;
    localparam int unsigned BW    = 26;
    localparam int unsigned MAXV  = 67108863;

    logic          clk;
    logic          reset;
    logic          load;
    logic [BW-1:0] bin_in;
    logic          blank_lz;
    logic          busy;
    logic [3:0]    bcd_out;
    logic [7:0]    anodes;

    int n_tests;
    int n_fail;
    bit chk_en;

    // reference model state
    int          m_cyc;
    int unsigned m_disp;
    int unsigned m_pend;
    int          m_busy_cnt;

    display_mux_bcd #(
        .REFRESH_DIV (RD),
        .BIN_W       (BW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .bin_in   (bin_in),
        .blank_lz (blank_lz),
        .busy     (busy),
        .bcd_out  (bcd_out),
        .anodes   (anodes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned pow10(input int unsigned k);
        int unsigned p;
        p = 1;
        for (int unsigned j = 0; j < k; j++) p = p * 10;
        return p;
    endfunction

    function automatic logic [3:0] exp_bcd(input int unsigned v, input int unsigned i, input logic blank);
        int unsigned p;
        p = pow10(i);
        if (blank && i != 0 && v < p) return 4'hF;
        return 4'((v / p) % 10);
    endfunction

    function automatic int unsigned model_idx();
        return (m_cyc / RD) % 8;
    endfunction

    // Model: a conversion takes BW+1 cycles after the accepting edge and then
    // replaces the displayed value; loads while busy are dropped.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cyc      <= 0;
            m_disp     <= 0;
            m_pend     <= 0;
            m_busy_cnt <= 0;
        end else begin
            m_cyc <= m_cyc + 1;
            if (m_busy_cnt > 0) begin
                m_busy_cnt <= m_busy_cnt - 1;
                if (m_busy_cnt == 1) m_disp <= m_pend;
            end else if (load) begin
                m_pend     <= int'(bin_in);
                m_busy_cnt <= BW + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [7:0] a;
            a = 8'hFF;
            a[model_idx()] = 1'b0;
            check("busy", busy, m_busy_cnt != 0);
            check("anodes", anodes, a);
            check("bcd_out", bcd_out, exp_bcd(m_disp, model_idx(), blank_lz));
        end
    end

    task automatic do_load(input int unsigned v);
        @(posedge clk);
        #2;
        load   = 1'b1;
        bin_in = BW'(v);
        @(posedge clk);
        #2;
        load   = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(posedge clk);
            #2;
        end
        if (n >= 100) check("busy_timeout", n, 0);
    endtask

    // One full frame: each digit must match its nibble of the expected word.
    task automatic check_frame(input string tag, input logic [31:0] word);
        int unsigned i;
        repeat (8 * RD) begin
            @(negedge clk);
            i = model_idx();
            check(tag, bcd_out, word[i*4 +: 4]);
        end
    endtask

    initial begin
        int n;
        int unsigned v;
        n_tests  = 0;
        n_fail   = 0;
        chk_en   = 1'b0;
        reset    = 1'b1;
        load     = 1'b0;
        bin_in   = '0;
        blank_lz = 1'b0;

        // Held reset: anode pattern must not advance.
        repeat (10) begin
            @(negedge clk);
            check("reset_anodes", anodes, 8'hFE);
            check("reset_bcd", bcd_out, 4'h0);
            check("reset_busy", busy, 1'b0);
        end
        @(posedge clk);
        #2;
        reset  = 1'b0;
        chk_en = 1'b1;

        // Scan sequence with value 0, no blanking.
        check_frame("zero_frame", 32'h00000000);

        // Conversion latency and digit order.
        do_load(12345678);
        wait_idle(n);
        check("busy_cycles", n, BW + 1);
        check_frame("frame_12345678", 32'h12345678);

        do_load(MAXV);
        wait_idle(n);
        check("busy_cycles_max", n, BW + 1);
        check_frame("frame_max", 32'h67108863);

        // Async reset between edges with nonzero display.
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("async_anodes", anodes, 8'hFE);
        check("async_bcd", bcd_out, 4'h0);
        check("async_busy", busy, 1'b0);
        @(posedge clk);
        #2;
        reset = 1'b0;

        // Leading-zero blanking.
        blank_lz = 1'b1;
        do_load(0);
        wait_idle(n);
        check_frame("blank_zero", 32'hFFFFFFF0);
        do_load(1005);
        wait_idle(n);
        check_frame("blank_1005", 32'hFFFF1005);
        blank_lz = 1'b0;

        // Load during conversion is dropped.
        do_load(42);
        repeat (9) @(posedge clk);
        #2;
        load   = 1'b1;
        bin_in = BW'(99);
        @(posedge clk);
        #2;
        load = 1'b0;
        wait_idle(n);
        repeat (40) begin
            @(negedge clk);
            check("no_second_conv", busy, 1'b0);
        end
        check_frame("dropped_load", 32'h00000042);

        // Reset in the middle of a conversion.
        do_load(500);
        repeat (11) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("midconv_busy", busy, 1'b0);
        check("midconv_bcd", bcd_out, 4'h0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        check_frame("midconv_frame", 32'h00000000);
        do_load(7);
        wait_idle(n);
        check("post_reset_busy", n, BW + 1);
        check_frame("post_reset_7", 32'h00000007);

        // Random values and blanking.
        for (int k = 0; k < 16; k++) begin
            v = $urandom_range(MAXV, 0);
            blank_lz = 1'($urandom_range(1, 0));
            do_load(v);
            wait_idle(n);
            check("rand_busy_cycles", n, BW + 1);
            repeat (8 * RD) @(negedge clk);
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
